// File: rtl/qspi_axil_bridge.sv
// AXI4-Lite slave front end for the QSPI flash low-level controller.
// Decodes read/program/erase from address bits and runs the LLC handshake.
module qspi_axil_bridge #(
  parameter int FLASH_AW         = 24,
  parameter int OP_RW_BIT        = 24,
  parameter int OP_ERASE_BIT     = 25,
  parameter int OP_ERASE_ALT_BIT = 26,
  parameter int PRESCALE         = 5,
  parameter int TIMEOUT          = 2**22
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic [31:0]         AWADDR,
  input  logic                AWVALID,
  input  logic [2:0]          AWPROT,
  output logic                AWREADY,
  input  logic [31:0]         WDATA,
  input  logic [3:0]          WSTRB,
  input  logic                WVALID,
  output logic                WREADY,
  output logic                BVALID,
  output logic [1:0]          BRESP,
  input  logic                BREADY,
  input  logic [31:0]         ARADDR,
  input  logic                ARVALID,
  input  logic [2:0]          ARPROT,
  output logic                ARREADY,
  output logic                RVALID,
  output logic [31:0]         RDATA,
  output logic [1:0]          RRESP,
  input  logic                RREADY,
  output logic                llc_start,
  output logic                llc_dir,
  output logic                llc_erase,
  output logic [FLASH_AW-1:0] llc_address,
  output logic [31:0]         llc_word,
  input  logic                llc_valid,
  input  logic [31:0]         llc_rdata,
  output logic                busy,
  output logic                timeout_flag
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [PW-1:0] PRE_LOAD = PW'(PRESCALE - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_BRESP = 3'd3;
  localparam logic [2:0] S_RRESP = 3'd4;

  logic [2:0]          r_state;
  logic                r_aw_l;
  logic                r_w_l;
  logic [31:0]         r_awaddr;
  logic [31:0]         r_wdata;
  logic [3:0]          r_wstrb;
  logic                r_is_rd;
  logic [PW-1:0]       r_pre;
  logic [TW-1:0]       r_to;
  logic [1:0]          r_bresp;
  logic [1:0]          r_rresp;
  logic [31:0]         r_rdata;
  logic                r_start;
  logic                r_dir;
  logic                r_erase;
  logic [FLASH_AW-1:0] r_addr;
  logic [31:0]         r_word;
  logic                r_tflag;

  logic w_idle;
  logic w_awready;
  logic w_wready;
  logic w_arready;
  logic w_tick;
  logic w_unused;

  assign w_idle    = !ARESET && (r_state == S_IDLE);
  assign w_awready = w_idle && !r_aw_l;
  assign w_wready  = w_idle && !r_w_l;
  // Pending write beats block reads so writes win simultaneous arrival.
  assign w_arready = w_idle && !r_aw_l && !r_w_l && !AWVALID && !WVALID;
  assign w_tick    = (r_pre == '0);
  assign w_unused  = ^{AWPROT, ARPROT, r_awaddr};

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state  <= S_IDLE;
      r_aw_l   <= 1'b0;
      r_w_l    <= 1'b0;
      r_awaddr <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
      r_is_rd  <= 1'b0;
      r_pre    <= '0;
      r_to     <= '0;
      r_bresp  <= '0;
      r_rresp  <= '0;
      r_rdata  <= '0;
      r_start  <= 1'b0;
      r_dir    <= 1'b0;
      r_erase  <= 1'b0;
      r_addr   <= '0;
      r_word   <= '0;
      r_tflag  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_awready && AWVALID) begin
            r_aw_l   <= 1'b1;
            r_awaddr <= AWADDR;
          end
          if (w_wready && WVALID) begin
            r_w_l   <= 1'b1;
            r_wdata <= WDATA;
            r_wstrb <= WSTRB;
          end
          if (r_aw_l && r_w_l) begin
            r_is_rd <= 1'b0;
            if (r_awaddr[OP_ERASE_BIT] || r_awaddr[OP_ERASE_ALT_BIT]) begin
              r_erase <= 1'b1;
              r_dir   <= r_awaddr[OP_ERASE_ALT_BIT];
              r_addr  <= r_awaddr[FLASH_AW-1:0];
              r_start <= 1'b1;
              r_state <= S_ISSUE;
            end else if (r_awaddr[OP_RW_BIT] && r_wstrb == 4'hF) begin
              r_dir   <= 1'b1;
              r_word  <= r_wdata;
              r_addr  <= r_awaddr[FLASH_AW-1:0];
              r_start <= 1'b1;
              r_state <= S_ISSUE;
            end else begin
              r_bresp <= 2'b10;
              r_state <= S_BRESP;
            end
          end else if (w_arready && ARVALID) begin
            r_is_rd <= 1'b1;
            if (ARADDR[OP_RW_BIT]) begin
              r_dir   <= 1'b0;
              r_erase <= 1'b0;
              r_addr  <= ARADDR[FLASH_AW-1:0];
              r_start <= 1'b1;
              r_state <= S_ISSUE;
            end else begin
              r_rdata <= '0;
              r_rresp <= 2'b10;
              r_state <= S_RRESP;
            end
          end
        end
        S_ISSUE: begin
          r_pre   <= PRE_LOAD;
          r_to    <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_to  <= r_to + 1'b1;
          r_pre <= w_tick ? PRE_LOAD : r_pre - 1'b1;
          // Abort takes priority over a valid tick in the same cycle.
          if (r_to == TO_LAST) begin
            r_start <= 1'b0;
            r_erase <= 1'b0;
            r_dir   <= 1'b0;
            r_addr  <= '0;
            r_tflag <= 1'b1;
            if (r_is_rd) begin
              r_rdata <= '0;
              r_rresp <= 2'b10;
              r_state <= S_RRESP;
            end else begin
              r_bresp <= 2'b10;
              r_state <= S_BRESP;
            end
          end else if (w_tick && llc_valid) begin
            r_start <= 1'b0;
            r_erase <= 1'b0;
            r_dir   <= 1'b0;
            r_addr  <= '0;
            if (r_is_rd) begin
              r_rdata <= llc_rdata;
              r_rresp <= 2'b00;
              r_state <= S_RRESP;
            end else begin
              r_bresp <= 2'b00;
              r_state <= S_BRESP;
            end
          end
        end
        S_BRESP: begin
          if (BREADY) begin
            r_aw_l  <= 1'b0;
            r_w_l   <= 1'b0;
            r_bresp <= 2'b00;
            r_state <= S_IDLE;
          end
        end
        S_RRESP: begin
          if (RREADY) begin
            r_rdata <= '0;
            r_rresp <= 2'b00;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign AWREADY      = w_awready;
  assign WREADY       = w_wready;
  assign ARREADY      = w_arready;
  assign BVALID       = (r_state == S_BRESP);
  assign BRESP        = r_bresp;
  assign RVALID       = (r_state == S_RRESP);
  assign RDATA        = r_rdata;
  assign RRESP        = r_rresp;
  assign llc_start    = r_start;
  assign llc_dir      = r_dir;
  assign llc_erase    = r_erase;
  assign llc_address  = r_addr;
  assign llc_word     = r_word;
  assign busy         = (r_state != S_IDLE);
  assign timeout_flag = r_tflag;

endmodule

// File: tb/tb_qspi_axil_bridge.sv
// Scoreboard bench for qspi_axil_bridge with a behavioural LLC model.
// Expected LLC requests and AXI responses are queued as stimulus is driven.
module tb_qspi_axil_bridge;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic [31:0] AWADDR = '0;
  logic        AWVALID = 1'b0;
  logic [2:0]  AWPROT = '0;
  logic        AWREADY;
  logic [31:0] WDATA = '0;
  logic [3:0]  WSTRB = '0;
  logic        WVALID = 1'b0;
  logic        WREADY;
  logic        BVALID;
  logic [1:0]  BRESP;
  logic        BREADY = 1'b1;
  logic [31:0] ARADDR = '0;
  logic        ARVALID = 1'b0;
  logic [2:0]  ARPROT = '0;
  logic        ARREADY;
  logic        RVALID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RREADY = 1'b1;
  logic        llc_start;
  logic        llc_dir;
  logic        llc_erase;
  logic [23:0] llc_address;
  logic [31:0] llc_word;
  logic        llc_valid = 1'b0;
  logic [31:0] llc_rdata = '0;
  logic        busy;
  logic        timeout_flag;

  qspi_axil_bridge #(.TIMEOUT(64)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWPROT(AWPROT),
    .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BVALID(BVALID), .BRESP(BRESP), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARPROT(ARPROT),
    .ARREADY(ARREADY),
    .RVALID(RVALID), .RDATA(RDATA), .RRESP(RRESP), .RREADY(RREADY),
    .llc_start(llc_start), .llc_dir(llc_dir), .llc_erase(llc_erase),
    .llc_address(llc_address), .llc_word(llc_word),
    .llc_valid(llc_valid), .llc_rdata(llc_rdata),
    .busy(busy), .timeout_flag(timeout_flag)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic        rd;
    logic [1:0]  resp;
    logic [31:0] data;
  } rsp_t;

  typedef struct {
    logic        dir;
    logic        erase;
    logic [23:0] addr;
    logic [31:0] word;
    logic        chk_word;
    int          len;
  } op_t;

  rsp_t sb_q[$];
  op_t  llc_q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   llc_delay = 12;

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic push_rsp(input logic rd, input logic [1:0] resp,
                          input logic [31:0] data);
    rsp_t r;
    r.rd = rd; r.resp = resp; r.data = data;
    sb_q.push_back(r);
  endtask

  task automatic push_op(input logic dir, input logic erase,
                         input logic [23:0] addr, input logic [31:0] word,
                         input logic chk_word, input int len);
    op_t o;
    o.dir = dir; o.erase = erase; o.addr = addr;
    o.word = word; o.chk_word = chk_word; o.len = len;
    llc_q.push_back(o);
  endtask

  // Response side of the scoreboard
  always @(negedge ACLK) begin
    rsp_t e;
    if (!ARESET && BVALID && BREADY) begin
      check("b_pending", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("b_order", 32'd0, 32'(e.rd));
        check("bresp", 32'(BRESP), 32'(e.resp));
      end
    end
    if (!ARESET && RVALID && RREADY) begin
      check("r_pending", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("r_order", 32'd1, 32'(e.rd));
        check("rresp", 32'(RRESP), 32'(e.resp));
        check("rdata", RDATA, e.data);
      end
    end
  end

  // LLC model: raises llc_valid llc_delay cycles after llc_start rises
  initial begin
    int   cnt;
    int   len;
    logic seen;
    op_t  e;
    cnt = 0; len = 0; seen = 1'b0;
    forever begin
      @(negedge ACLK);
      if (ARESET) begin
        seen = 1'b0; llc_valid = 1'b0; cnt = 0;
      end else if (llc_start && !seen) begin
        seen = 1'b1; cnt = 1; len = 0;
        check("llc_pending", 32'(llc_q.size() != 0), 32'd1);
        if (llc_q.size() != 0) begin
          e = llc_q.pop_front();
          len = e.len;
          check("llc_dir", 32'(llc_dir), 32'(e.dir));
          check("llc_erase", 32'(llc_erase), 32'(e.erase));
          check("llc_addr", 32'(llc_address), 32'(e.addr));
          if (e.chk_word) check("llc_word", llc_word, e.word);
        end
      end else if (llc_start) begin
        cnt++;
        if (cnt == llc_delay) llc_valid = 1'b1;
      end else if (seen) begin
        seen = 1'b0; llc_valid = 1'b0;
        if (len != 0) check("llc_len", 32'(cnt), 32'(len));
      end
    end
  end

  task automatic send_aw(input logic [31:0] a);
    logic ok;
    ok = 1'b0;
    @(posedge ACLK); #1;
    AWADDR = a; AWVALID = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge ACLK);
      if (AWREADY) begin ok = 1'b1; break; end
    end
    @(posedge ACLK); #1;
    AWVALID = 1'b0;
    check("aw_hs", 32'(ok), 32'd1);
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    logic ok;
    ok = 1'b0;
    @(posedge ACLK); #1;
    WDATA = d; WSTRB = s; WVALID = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge ACLK);
      if (WREADY) begin ok = 1'b1; break; end
    end
    @(posedge ACLK); #1;
    WVALID = 1'b0;
    check("w_hs", 32'(ok), 32'd1);
  endtask

  task automatic send_ar(input logic [31:0] a);
    logic ok;
    ok = 1'b0;
    @(posedge ACLK); #1;
    ARADDR = a; ARVALID = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge ACLK);
      if (ARREADY) begin ok = 1'b1; break; end
    end
    @(posedge ACLK); #1;
    ARVALID = 1'b0;
    check("ar_hs", 32'(ok), 32'd1);
  endtask

  task automatic wait_done();
    int leak;
    leak = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge ACLK);
      if (busy && ARREADY) leak++;
      if (sb_q.size() == 0) break;
    end
    check("drain", 32'(sb_q.size()), 32'd0);
    check("ar_busy", 32'(leak), 32'd0);
    @(posedge ACLK); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    check("rst_awready", 32'(AWREADY), 32'd0);
    check("rst_arready", 32'(ARREADY), 32'd0);
    check("rst_valids", 32'({BVALID, RVALID, llc_start, busy}), 32'd0);
    check("rst_tflag", 32'(timeout_flag), 32'd0);
    check("rst_rdata", RDATA, 32'd0);
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    @(negedge ACLK);
    check("idle_awready", 32'(AWREADY), 32'd1);

    // flash read
    llc_rdata = 32'hDEADBEEF;
    push_op(1'b0, 1'b0, 24'h000040, '0, 1'b0, 0);
    push_rsp(1'b1, 2'b00, 32'hDEADBEEF);
    send_ar(32'h0100_0040);
    wait_done();

    // program with W two cycles ahead of AW
    push_op(1'b1, 1'b0, 24'h000010, 32'h12345678, 1'b1, 0);
    push_rsp(1'b0, 2'b00, '0);
    fork
      send_w(32'h12345678, 4'hF);
      begin
        repeat (2) @(posedge ACLK);
        send_aw(32'h0100_0010);
      end
    join
    wait_done();

    // alternate erase and sector erase
    push_op(1'b1, 1'b1, 24'h001000, '0, 1'b0, 0);
    push_rsp(1'b0, 2'b00, '0);
    fork
      send_aw(32'h0400_1000);
      send_w(32'hFFFF_FFFF, 4'hF);
    join
    wait_done();
    push_op(1'b0, 1'b1, 24'h001000, '0, 1'b0, 0);
    push_rsp(1'b0, 2'b00, '0);
    fork
      send_aw(32'h0200_1000);
      send_w(32'h0, 4'h0);
    join
    wait_done();

    // decode errors
    push_rsp(1'b0, 2'b10, '0);
    fork
      send_aw(32'h0100_0010);
      send_w(32'h5555_AAAA, 4'h3);
    join
    wait_done();
    push_rsp(1'b1, 2'b10, 32'h0);
    send_ar(32'h0000_0004);
    wait_done();

    // B backpressure
    BREADY = 1'b0;
    push_op(1'b1, 1'b0, 24'h000020, 32'hA5A5_5A5A, 1'b1, 0);
    push_rsp(1'b0, 2'b00, '0);
    fork
      send_aw(32'h0100_0020);
      send_w(32'hA5A5_5A5A, 4'hF);
    join
    for (int i = 0; i < 200; i++) begin
      @(negedge ACLK);
      if (BVALID) break;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge ACLK);
      check("bp_bvalid", 32'(BVALID), 32'd1);
      check("bp_bresp", 32'(BRESP), 32'd0);
    end
    @(posedge ACLK); #1;
    BREADY = 1'b1;
    wait_done();

    // simultaneous AW/W/AR: write first
    llc_rdata = 32'hCAFE_0001;
    push_op(1'b1, 1'b0, 24'h000050, 32'h0BAD_F00D, 1'b1, 0);
    push_rsp(1'b0, 2'b00, '0);
    push_op(1'b0, 1'b0, 24'h000060, '0, 1'b0, 0);
    push_rsp(1'b1, 2'b00, 32'hCAFE_0001);
    fork
      send_aw(32'h0100_0050);
      send_w(32'h0BAD_F00D, 4'hF);
      send_ar(32'h0100_0060);
    join
    wait_done();

    // timeout: one ISSUE cycle plus 64 WAIT cycles of llc_start
    llc_delay = 1000000;
    push_op(1'b1, 1'b0, 24'h000030, 32'h1111_2222, 1'b1, 65);
    push_rsp(1'b0, 2'b10, '0);
    fork
      send_aw(32'h0100_0030);
      send_w(32'h1111_2222, 4'hF);
    join
    wait_done();
    check("tflag_set", 32'(timeout_flag), 32'd1);
    llc_delay = 12;

    // flag is sticky across a good op
    llc_rdata = 32'h0000_7777;
    push_op(1'b0, 1'b0, 24'h000070, '0, 1'b0, 0);
    push_rsp(1'b1, 2'b00, 32'h0000_7777);
    send_ar(32'h0100_0070);
    wait_done();
    check("tflag_sticky", 32'(timeout_flag), 32'd1);

    // asynchronous reset mid-WAIT
    push_op(1'b0, 1'b0, 24'h000080, '0, 1'b0, 0);
    push_rsp(1'b1, 2'b00, 32'h0000_7777);
    send_ar(32'h0100_0080);
    for (int i = 0; i < 200; i++) begin
      @(negedge ACLK);
      if (llc_start) break;
    end
    repeat (4) @(negedge ACLK);
    check("pre_rst_start", 32'(llc_start), 32'd1);
    #2;
    ARESET = 1'b1;
    #1;
    check("arst_start", 32'(llc_start), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_tflag", 32'(timeout_flag), 32'd0);
    check("arst_outs",
          32'({BVALID, RVALID, AWREADY, ARREADY, llc_dir, llc_erase}),
          32'd0);
    check("arst_addr", 32'(llc_address), 32'd0);
    sb_q.delete();
    llc_q.delete();
    repeat (2) @(posedge ACLK);
    #1;
    ARESET = 1'b0;

    // recovery read
    llc_rdata = 32'h3C3C_C3C3;
    push_op(1'b0, 1'b0, 24'h000090, '0, 1'b0, 0);
    push_rsp(1'b1, 2'b00, 32'h3C3C_C3C3);
    send_ar(32'h0100_0090);
    wait_done();

    repeat (5) @(posedge ACLK);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
